// File: rtl/f1_start_ctrl.sv
// ---------------------------------------------------------------------------
// f1_start_ctrl
//
// Sequencer for the F1 start-light demo. After a trigger it builds up the
// 8-light bar one light per tick, holds the full bar for a pseudo-random
// number of ticks taken from the LFSR, blanks the bar and then counts clock
// cycles until the driver presses react. Pressing react before the bar goes
// dark is reported as a false start.
//
// Parameters:
//   DLY_BITS    number of low LFSR bits used as the random hold (1..8)
//   TIME_W      width of the reaction counter and time_out
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   trigger     start request, honoured only while idle
//   tick        one-cycle pacing strobe for the build-up and the hold
//   react       driver button, sampled every cycle
//   lfsr_data   current LFSR value
//   lfsr_en     LFSR advance enable (high only while idle)
//   lights      light bar, bit 0 lights first
//   busy        high whenever a run is in progress
//   false_start one-cycle pulse on a premature react
//   time_valid  one-cycle pulse when time_out is updated
//   time_out    last measured reaction time in cycles
// ---------------------------------------------------------------------------
module f1_start_ctrl #(
    parameter int DLY_BITS = 3,
    parameter int TIME_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger,
    input  logic              tick,
    input  logic              react,
    input  logic [7:0]        lfsr_data,
    output logic              lfsr_en,
    output logic [7:0]        lights,
    output logic              busy,
    output logic              false_start,
    output logic              time_valid,
    output logic [TIME_W-1:0] time_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEQ   = 2'd1,
        DELAY = 2'd2,
        GO    = 2'd3
    } state_t;

    localparam logic [TIME_W-1:0] RCNT_MAX = '1;

    state_t              r_state;
    logic [7:0]          r_lights;
    logic [DLY_BITS-1:0] r_dcnt;
    logic [TIME_W-1:0]   r_rcnt;
    logic [TIME_W-1:0]   r_time_out;
    logic                r_false_start;
    logic                r_time_valid;

    // Only the low DLY_BITS of the LFSR feed the hold counter; the rest of
    // the bus is deliberately left unused.
    logic w_unused_lfsr;
    assign w_unused_lfsr = ^lfsr_data;

    // The LFSR keeps running while idle so the hold length depends on when
    // the driver triggers, and is frozen for the duration of a run.
    assign lfsr_en     = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign lights      = r_lights;
    assign false_start = r_false_start;
    assign time_valid  = r_time_valid;
    assign time_out    = r_time_out;

    // Single sequencer process. The pulse outputs default low every cycle so
    // they can never stretch, even with react held down. In SEQ and DELAY the
    // react check comes before the tick check so a press wins over a tick in
    // the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_lights      <= 8'h00;
            r_dcnt        <= '0;
            r_rcnt        <= '0;
            r_time_out    <= '0;
            r_false_start <= 1'b0;
            r_time_valid  <= 1'b0;
        end else begin
            r_false_start <= 1'b0;
            r_time_valid  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (trigger) begin
                        r_state  <= SEQ;
                        r_lights <= 8'h01;
                    end
                end
                SEQ: begin
                    if (react) begin
                        r_lights      <= 8'h00;
                        r_false_start <= 1'b1;
                        r_state       <= IDLE;
                    end else if (tick) begin
                        if (r_lights != 8'hFF) begin
                            r_lights <= {r_lights[6:0], 1'b1};
                        end else begin
                            r_dcnt  <= lfsr_data[DLY_BITS-1:0];
                            r_state <= DELAY;
                        end
                    end
                end
                DELAY: begin
                    // The counter is checked before decrementing, so a
                    // captured value K holds the bar for K+1 ticks.
                    if (react) begin
                        r_lights      <= 8'h00;
                        r_false_start <= 1'b1;
                        r_state       <= IDLE;
                    end else if (tick) begin
                        if (r_dcnt != '0) begin
                            r_dcnt <= r_dcnt - 1'b1;
                        end else begin
                            r_lights <= 8'h00;
                            r_rcnt   <= '0;
                            r_state  <= GO;
                        end
                    end
                end
                GO: begin
                    if (react) begin
                        r_time_out   <= r_rcnt;
                        r_time_valid <= 1'b1;
                        r_state      <= IDLE;
                    end else if (r_rcnt != RCNT_MAX) begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f1_start_ctrl.sv
// ---------------------------------------------------------------------------
// tb_f1_start_ctrl
//
// Drives two instances of f1_start_ctrl from the same inputs: one with the
// default 16-bit reaction counter and one with a 4-bit counter so that
// saturation can be exercised. Light-bar state is checked directly after
// each stimulus step; false-start and reaction-time events are predicted
// into a scoreboard queue and consumed by an independent monitor.
// ---------------------------------------------------------------------------
module tb_f1_start_ctrl;

    logic        clk;
    logic        rst;
    logic        trigger;
    logic        tick;
    logic        react;
    logic [7:0]  lfsrData;

    logic        lfsrEn;
    logic [7:0]  lightsOut;
    logic        busyOut;
    logic        falseStart;
    logic        timeValid;
    logic [15:0] timeOut;

    logic        lfsrEnS;
    logic [7:0]  lightsOutS;
    logic        busyOutS;
    logic        falseStartS;
    logic        timeValidS;
    logic [3:0]  timeOutS;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        isFalse;
        logic [15:0] t16;
        logic [3:0]  t4;
    } expT;

    expT sbQueue[$];
    expT monExp;

    f1_start_ctrl #(.DLY_BITS(3), .TIME_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .trigger(trigger),
        .tick(tick),
        .react(react),
        .lfsr_data(lfsrData),
        .lfsr_en(lfsrEn),
        .lights(lightsOut),
        .busy(busyOut),
        .false_start(falseStart),
        .time_valid(timeValid),
        .time_out(timeOut)
    );

    f1_start_ctrl #(.DLY_BITS(3), .TIME_W(4)) dutSat (
        .clk(clk),
        .rst(rst),
        .trigger(trigger),
        .tick(tick),
        .react(react),
        .lfsr_data(lfsrData),
        .lfsr_en(lfsrEnS),
        .lights(lightsOutS),
        .busy(busyOutS),
        .false_start(falseStartS),
        .time_valid(timeValidS),
        .time_out(timeOutS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expLights,
                               input logic expBusy, input logic expEn);
        checks++;
        if ({lightsOut, busyOut, lfsrEn} !== {expLights, expBusy, expEn}) begin
            errors++;
            $display("[TB] FAIL %s (main): got lights=%h busy=%b lfsr_en=%b, expected lights=%h busy=%b lfsr_en=%b",
                     name, lightsOut, busyOut, lfsrEn, expLights, expBusy, expEn);
        end
        checks++;
        if ({lightsOutS, busyOutS, lfsrEnS} !== {expLights, expBusy, expEn}) begin
            errors++;
            $display("[TB] FAIL %s (sat): got lights=%h busy=%b lfsr_en=%b, expected lights=%h busy=%b lfsr_en=%b",
                     name, lightsOutS, busyOutS, lfsrEnS, expLights, expBusy, expEn);
        end
    endtask

    task automatic applyStimulus(input logic trig, input logic tk, input logic rc);
        trigger = trig;
        tick    = tk;
        react   = rc;
        @(posedge clk);
        #1;
    endtask

    task automatic doTick(input logic trigIdle);
        for (int i = 0; i < 3; i++) applyStimulus(trigIdle, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
    endtask

    task automatic startAndFill();
        logic [8:0] expBar;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("first light", 8'h01, 1'b1, 1'b0);
        for (int n = 1; n <= 7; n++) begin
            doTick(n == 3);
            expBar = (9'd1 << (n + 1)) - 9'd1;
            checkOutput($sformatf("seq light %0d", n + 1), expBar[7:0], 1'b1, 1'b0);
        end
        doTick(1'b0);
        checkOutput("enter delay", 8'hFF, 1'b1, 1'b0);
    endtask

    task automatic expectEvent(input logic isFalse, input logic [15:0] t16, input logic [3:0] t4);
        expT e;
        e.isFalse = isFalse;
        e.t16     = t16;
        e.t4      = t4;
        sbQueue.push_back(e);
    endtask

    // Scoreboard monitor: every cycle in which either instance raises a pulse
    // consumes one predicted event and compares both instances against it.
    always @(negedge clk) begin
        if (!rst && (timeValid || falseStart || timeValidS || falseStartS)) begin
            if (sbQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected event: got fs=%b tv=%b fsS=%b tvS=%b, expected none",
                         falseStart, timeValid, falseStartS, timeValidS);
            end else begin
                monExp = sbQueue.pop_front();
                checkValue("event kind main", {30'd0, falseStart, timeValid},
                           {30'd0, monExp.isFalse, ~monExp.isFalse});
                checkValue("event kind sat", {30'd0, falseStartS, timeValidS},
                           {30'd0, monExp.isFalse, ~monExp.isFalse});
                checkValue("time_out main", {16'd0, timeOut}, {16'd0, monExp.t16});
                checkValue("time_out sat", {28'd0, timeOutS}, {28'd0, monExp.t4});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        trigger  = 1'b0;
        tick     = 1'b0;
        react    = 1'b0;
        lfsrData = 8'h05;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset state", 8'h00, 1'b0, 1'b1);
        checkValue("reset time_out main", {16'd0, timeOut}, 32'd0);
        checkValue("reset time_out sat", {28'd0, timeOutS}, 32'd0);

        $display("[TB] full run, K=5");
        startAndFill();
        for (int d = 1; d <= 5; d++) begin
            doTick(1'b0);
            checkOutput($sformatf("delay hold %0d", d), 8'hFF, 1'b1, 1'b0);
        end
        doTick(1'b0);
        checkOutput("lights out", 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        expectEvent(1'b0, 16'd9, 4'd9);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("idle after react", 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] false start at 8'h07");
        applyStimulus(1'b1, 1'b0, 1'b0);
        doTick(1'b0);
        doTick(1'b0);
        checkOutput("three lights", 8'h07, 1'b1, 1'b0);
        expectEvent(1'b1, 16'd9, 4'd9);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("false start clears", 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] react and tick together in SEQ");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectEvent(1'b1, 16'd9, 4'd9);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("react beats tick", 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] minimum delay, K=0");
        lfsrData = 8'h08;
        startAndFill();
        doTick(1'b0);
        checkOutput("min delay lights out", 8'h00, 1'b1, 1'b0);
        expectEvent(1'b0, 16'd0, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle after fast react", 8'h00, 1'b0, 1'b1);

        $display("[TB] saturation");
        startAndFill();
        doTick(1'b0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkValue("sat rcnt holds", {28'd0, dutSat.r_rcnt}, 32'd15);
        expectEvent(1'b0, 16'd40, 4'd15);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] asynchronous reset mid-delay");
        lfsrData = 8'h05;
        startAndFill();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset", 8'h00, 1'b0, 1'b1);
        checkValue("async reset time_out main", {16'd0, timeOut}, 32'd0);
        checkValue("async reset time_out sat", {28'd0, timeOutS}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle after reset", 8'h00, 1'b0, 1'b1);

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        checkValue("scoreboard drained", sbQueue.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
